// File: rtl/spi_seq_pkg.sv
// Shared types for the SPI transfer sequencer.
// Register indices, sequencer states and APB phases.
package spi_seq_pkg;

  localparam logic [3:0] REG_CONFIG = 4'd0;
  localparam logic [3:0] REG_TX     = 4'd1;
  localparam logic [3:0] REG_RX     = 4'd1;
  localparam logic [3:0] REG_CMD    = 4'd3;
  localparam logic [3:0] REG_STATE  = 4'd0;

  typedef enum logic [2:0] {
    S_CFG,
    S_IDLE,
    S_TX,
    S_CMD,
    S_POLL,
    S_RXRD,
    S_DONE
  } seq_state_e;

  typedef enum logic [2:0] {
    B_IDLE,
    B_SETUP,
    B_ACCESS,
    B_GAP,
    B_RDWAIT
  } bus_phase_e;

endpackage

// File: rtl/spi_xfer_sequencer_apb.sv
// APB phase engine: one register access per start, pulses ack on its last cycle.
// A start accepted in the ack cycle chains the next SETUP with no idle cycle.
module apb_master_phase
  import spi_seq_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] base_i,
  input  logic       start_i,
  input  logic       write_i,
  input  logic [3:0] idx_i,
  input  logic [7:0] wdata_i,
  output logic       ack_o,
  output logic       idle_o,
  output logic [7:0] rdata_o,
  output logic       psel_o,
  output logic       penable_o,
  output logic       pwrite_o,
  output logic [15:0] paddr_o,
  output logic [7:0] pwdata_o,
  input  logic [7:0] prdata_i,
  input  logic       pready_i
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(RD_LAT - 1);

  bus_phase_e    phase_q;
  logic [CW-1:0] cnt_q;
  logic [15:0]   addr_q;
  logic [7:0]    wdata_q;
  logic          write_q;
  logic          load;

  assign ack_o = (phase_q == B_GAP) ||
                 (phase_q == B_RDWAIT && cnt_q == LAST);
  assign idle_o = (phase_q == B_IDLE);
  assign load = start_i && (idle_o || ack_o);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= B_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else if (load) begin
      phase_q <= B_SETUP;
      addr_q  <= {base_i, idx_i, 2'b00};
      wdata_q <= wdata_i;
      write_q <= write_i;
    end else if (ack_o) begin
      phase_q <= B_IDLE;
    end else begin
      unique case (phase_q)
        B_SETUP: phase_q <= B_ACCESS;
        B_ACCESS: begin
          if (pready_i) begin
            phase_q <= write_q ? B_GAP : B_RDWAIT;
            cnt_q   <= '0;
          end
        end
        B_RDWAIT: cnt_q <= cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign psel_o    = (phase_q == B_SETUP) || (phase_q == B_ACCESS);
  assign penable_o = (phase_q == B_ACCESS);
  assign pwrite_o  = psel_o & write_q;
  assign paddr_o   = psel_o ? addr_q : '0;
  assign pwdata_o  = psel_o ? wdata_q : '0;
  // Read data is consumed in the ack cycle, at the sampling edge.
  assign rdata_o   = prdata_i;

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Round-robin APB sequencer for a shared SPI register block.
// Define SPI_SEQ_TIMEOUT_EN to bound STATE polling by POLL_MAX.
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter int          NREQ      = 2,
  parameter logic [7:0]  CFG_VAL   = 8'h00,
  parameter logic [7:0]  CMD_START = 8'h01,
  parameter int          BUSY_BIT  = 0,
  parameter int          RD_LAT    = 2,
  parameter int          POLL_MAX  = 16
) (
  input  logic              i_PCLK,
  input  logic              i_PRESET,
  input  logic [9:0]        i_BASE_ADDR,
  output logic              o_PSEL,
  output logic              o_PENABLE,
  output logic              o_PWRITE,
  output logic [15:0]       o_PADDR,
  output logic [7:0]        o_PWDATA,
  input  logic [7:0]        i_PRDATA,
  input  logic              i_PREADY,
  input  logic [NREQ-1:0]   i_req,
  input  logic [8*NREQ-1:0] i_req_data,
  output logic [NREQ-1:0]   o_gnt,
  output logic [NREQ-1:0]   o_done,
  output logic [7:0]        o_rdata,
  output logic              o_err,
  output logic              o_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  seq_state_e      state_q, state_d;
  logic [PW-1:0]   ptr_q, win, kk;
  logic [NREQ-1:0] gnt_q, done_q;
  logic [7:0]      rdata_q;
  logic            err_q, busy_q;
  logic            any_req;
  logic [7:0]      sel_data;
  logic [7:0]      data_arr [NREQ];

  logic       start, wr, ack, bidle, tmo;
  logic [3:0] idx;
  logic [7:0] wd, brdata;

  for (genvar g = 0; g < NREQ; g++) begin : g_data
    assign data_arr[g] = i_req_data[g*8 +: 8];
  end

  always_comb begin
    any_req  = 1'b0;
    win      = '0;
    kk       = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      kk = PW'((int'(ptr_q) + i) % NREQ);
      if (!any_req && i_req[kk]) begin
        any_req  = 1'b1;
        win      = kk;
        sel_data = data_arr[kk];
      end
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int PCW = $clog2(POLL_MAX + 1);
  logic [PCW-1:0] poll_q;

  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET) poll_q <= '0;
    else if (state_q == S_CMD && ack) poll_q <= '0;
    else if (state_q == S_POLL && ack) poll_q <= poll_q + 1'b1;
  end

  assign tmo = (poll_q == PCW'(POLL_MAX - 1));
`else
  // Polling is unbounded; POLL_MAX has no effect in this build.
  assign tmo = (POLL_MAX < 0);
`endif

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    wr      = 1'b0;
    idx     = REG_CONFIG;
    wd      = '0;
    unique case (state_q)
      S_CFG: begin
        if (ack) begin
          state_d = S_IDLE;
        end else if (bidle) begin
          start = 1'b1;
          wr    = 1'b1;
          wd    = CFG_VAL;
        end
      end
      S_IDLE: begin
        if (any_req) begin
          start   = 1'b1;
          wr      = 1'b1;
          idx     = REG_TX;
          wd      = sel_data;
          state_d = S_TX;
        end
      end
      S_TX: begin
        if (ack) begin
          start   = 1'b1;
          wr      = 1'b1;
          idx     = REG_CMD;
          wd      = CMD_START;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (ack) begin
          start   = 1'b1;
          idx     = REG_STATE;
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        if (ack) begin
          if (!brdata[BUSY_BIT]) begin
            start   = 1'b1;
            idx     = REG_RX;
            state_d = S_RXRD;
          end else if (tmo) begin
            state_d = S_DONE;
          end else begin
            start = 1'b1;
            idx   = REG_STATE;
          end
        end
      end
      S_RXRD: if (ack) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_CFG;
    endcase
  end

  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET) begin
      state_q <= S_CFG;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (any_req) begin
            gnt_q      <= '0;
            gnt_q[win] <= 1'b1;
            ptr_q <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
            err_q <= 1'b0;
          end
        end
        S_POLL: begin
          if (ack && brdata[BUSY_BIT] && tmo) begin
            done_q  <= gnt_q;
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        S_RXRD: begin
          if (ack) begin
            done_q  <= gnt_q;
            rdata_q <= brdata;
            err_q   <= 1'b0;
          end
        end
        S_DONE: gnt_q <= '0;
        default: ;
      endcase
    end
  end

  apb_master_phase #(.RD_LAT(RD_LAT)) u_apb (
    .clk_i     (i_PCLK),
    .rst_i     (i_PRESET),
    .base_i    (i_BASE_ADDR),
    .start_i   (start),
    .write_i   (wr),
    .idx_i     (idx),
    .wdata_i   (wd),
    .ack_o     (ack),
    .idle_o    (bidle),
    .rdata_o   (brdata),
    .psel_o    (o_PSEL),
    .penable_o (o_PENABLE),
    .pwrite_o  (o_PWRITE),
    .paddr_o   (o_PADDR),
    .pwdata_o  (o_PWDATA),
    .prdata_i  (i_PRDATA),
    .pready_i  (i_PREADY)
  );

  assign o_gnt   = gnt_q;
  assign o_done  = done_q;
  assign o_rdata = rdata_q;
  assign o_err   = err_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a small APB slave model.
// Timeout scenario runs only when SPI_SEQ_TIMEOUT_EN is defined.
module tb_spi_xfer_sequencer;

  localparam int NREQ = 2;
  localparam logic [7:0] CFG = 8'h5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] base = 10'h001;
  logic psel, pen, pwr, pready;
  logic [15:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata = 8'h00;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] gnt, done;
  logic [8*NREQ-1:0] req_data = '0;
  logic [7:0] rdata;
  logic err, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_xfer_sequencer #(
    .NREQ(NREQ), .CFG_VAL(CFG), .CMD_START(8'h01),
    .BUSY_BIT(0), .RD_LAT(2), .POLL_MAX(4)
  ) dut (
    .i_PCLK(clk), .i_PRESET(rst), .i_BASE_ADDR(base),
    .o_PSEL(psel), .o_PENABLE(pen), .o_PWRITE(pwr),
    .o_PADDR(paddr), .o_PWDATA(pwdata),
    .i_PRDATA(prdata), .i_PREADY(pready),
    .i_req(req), .i_req_data(req_data),
    .o_gnt(gnt), .o_done(done), .o_rdata(rdata),
    .o_err(err), .o_busy(busy)
  );

  // slave model and bus monitor
  int cyc = 0;
  int stall_cfg = 0;
  int stall_cnt = 0;
  int busy_n = 0;
  int pcount = 0;
  int nwr = 0, nrd = 0, ndone = 0;
  int multi = 0, unstable = 0;
  int acc_run = 0, cmd_len = 0;
  logic [15:0] s_addr = '0;
  logic [7:0] s_data = '0;
  logic [15:0] wa [512];
  logic [7:0]  wdv [512];
  logic [15:0] ra [512];

  assign pready = !(psel && pen && pwr && paddr[5:2] == 4'd3
                    && stall_cnt < stall_cfg);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (psel && pen && !pready) stall_cnt <= stall_cnt + 1;
    else if (!psel) stall_cnt <= 0;
  end

  always @(negedge clk) begin
    if (psel && !pen) begin
      s_addr = paddr;
      s_data = pwdata;
      acc_run = 0;
    end
    if (psel && pen) begin
      acc_run++;
      if (paddr !== s_addr || (pwr && pwdata !== s_data)) unstable++;
      if (pready) begin
        if (pwr) begin
          wa[nwr % 512] = paddr;
          wdv[nwr % 512] = pwdata;
          nwr++;
          if (paddr[5:2] == 4'd3) begin
            pcount = 0;
            cmd_len = acc_run;
          end
        end else begin
          ra[nrd % 512] = paddr;
          nrd++;
          if (paddr[5:2] == 4'd0) begin
            prdata = (pcount < busy_n) ? 8'h01 : 8'h00;
            pcount++;
          end else begin
            prdata = 8'h3C;
          end
        end
      end
    end
    if ($countones(gnt) > 1) multi++;
    if (done != '0) ndone++;
  end

  task automatic wait_done(output int lat, output logic [NREQ-1:0] who,
                           output logic [7:0] rd, output logic er,
                           output bit ok);
    int g;
    g = -1;
    ok = 0;
    lat = -1;
    who = '0;
    rd = '0;
    er = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (g < 0 && gnt != '0) g = cyc;
      if (done != '0) begin
        lat = cyc - g;
        who = done;
        rd = rdata;
        er = err;
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({psel, pen, pwr, paddr, pwdata, gnt, done, rdata, err, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got nonzero, want all 0");
    end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (nwr !== 1) begin
      n_bad++; $display("FAIL cfg_count: got %0d want 1", nwr);
    end
    n_cmp++;
    if (wa[0] !== 16'h0040) begin
      n_bad++; $display("FAIL cfg_addr: got %h want 0040", wa[0]);
    end
    n_cmp++;
    if (wdv[0] !== CFG) begin
      n_bad++; $display("FAIL cfg_data: got %h want %h", wdv[0], CFG);
    end
    n_cmp++;
    if ({nrd, psel, busy} !== {32'd0, 2'b00}) begin
      n_bad++; $display("FAIL cfg_idle: rd=%0d psel=%b busy=%b want 0", nrd, psel, busy);
    end
  endtask

  task automatic test_single;
    int lat, w0, r0;
    logic [NREQ-1:0] who;
    logic [7:0] rd;
    logic er;
    bit ok;
    w0 = nwr;
    r0 = nrd;
    req_data = {8'h00, 8'hA5};
    req = 2'b01;
    wait_done(lat, who, rd, er, ok);
    req = '0;
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL single_timeout: no done, want done"); end
    n_cmp++;
    if (lat !== 14) begin n_bad++; $display("FAIL single_lat: got %0d want 14", lat); end
    n_cmp++;
    if (who !== 2'b01) begin n_bad++; $display("FAIL single_who: got %b want 01", who); end
    n_cmp++;
    if ({rd, er} !== {8'h3C, 1'b0}) begin
      n_bad++; $display("FAIL single_rdata: got %h/%b want 3c/0", rd, er);
    end
    n_cmp++;
    if ({wa[w0], wdv[w0], wa[w0+1], wdv[w0+1]} !== {16'h0044, 8'hA5, 16'h004C, 8'h01}) begin
      n_bad++;
      $display("FAIL single_writes: got %h=%h %h=%h want 0044=a5 004c=01",
               wa[w0], wdv[w0], wa[w0+1], wdv[w0+1]);
    end
    n_cmp++;
    if ({nrd - r0, ra[r0], ra[r0+1]} !== {32'd2, 16'h0040, 16'h0044}) begin
      n_bad++;
      $display("FAIL single_reads: got n=%0d %h %h want 2 0040 0044",
               nrd - r0, ra[r0], ra[r0+1]);
    end
    @(negedge clk);
    n_cmp++;
    if ({gnt, busy} !== 3'b000) begin
      n_bad++; $display("FAIL single_after: gnt=%b busy=%b want 0", gnt, busy);
    end
  endtask

  task automatic test_back_to_back;
    int lat, w0;
    logic [NREQ-1:0] who;
    logic [NREQ-1:0] exp_who;
    logic [7:0] exp_d;
    logic [7:0] rd;
    logic er;
    bit ok;
    int m0;
    m0 = multi;
    req_data = {8'h22, 8'h11};
    req = 2'b11;
    // pointer sits at 1 after the single transfer granted requester 0
    for (int k = 0; k < 4; k++) begin
      exp_who = (k % 2 == 0) ? 2'b10 : 2'b01;
      exp_d = (k % 2 == 0) ? 8'h22 : 8'h11;
      w0 = nwr;
      wait_done(lat, who, rd, er, ok);
      if (k == 3) req = '0;
      n_cmp++;
      if (!ok || who !== exp_who) begin
        n_bad++; $display("FAIL b2b_gnt%0d: got %b want %b", k, who, exp_who);
      end
      n_cmp++;
      if (wdv[w0] !== exp_d) begin
        n_bad++; $display("FAIL b2b_data%0d: got %h want %h", k, wdv[w0], exp_d);
      end
    end
    n_cmp++;
    if (multi !== m0) begin
      n_bad++; $display("FAIL b2b_onehot: got %0d multi-grant cycles want 0", multi - m0);
    end
  endtask

  task automatic test_polls;
    int lat, r0;
    logic [NREQ-1:0] who;
    logic [7:0] rd;
    logic er;
    bit ok;
    r0 = nrd;
    busy_n = 3;
    req_data = {8'h00, 8'h77};
    req = 2'b01;
    wait_done(lat, who, rd, er, ok);
    req = '0;
    busy_n = 0;
    n_cmp++;
    if (!ok || lat !== 26) begin
      n_bad++; $display("FAIL polls_lat: got %0d want 26", lat);
    end
    n_cmp++;
    if (nrd - r0 !== 5 || rd !== 8'h3C) begin
      n_bad++; $display("FAIL polls_reads: got %0d reads rd=%h want 5 3c", nrd - r0, rd);
    end
    @(negedge clk);
  endtask

  task automatic test_stall;
    int lat, u0;
    logic [NREQ-1:0] who;
    logic [7:0] rd;
    logic er;
    bit ok;
    u0 = unstable;
    stall_cfg = 2;
    req_data = {8'h00, 8'h5C};
    req = 2'b01;
    wait_done(lat, who, rd, er, ok);
    req = '0;
    stall_cfg = 0;
    n_cmp++;
    if (!ok || lat !== 16) begin
      n_bad++; $display("FAIL stall_lat: got %0d want 16", lat);
    end
    n_cmp++;
    if (cmd_len !== 3) begin
      n_bad++; $display("FAIL stall_access: got %0d cycles want 3", cmd_len);
    end
    n_cmp++;
    if (unstable !== u0) begin
      n_bad++; $display("FAIL stall_stable: got %0d unstable want 0", unstable - u0);
    end
    @(negedge clk);
  endtask

`ifdef SPI_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    int lat, r0;
    logic [NREQ-1:0] who;
    logic [7:0] rd;
    logic er;
    bit ok;
    r0 = nrd;
    busy_n = 1000;
    req = 2'b01;
    wait_done(lat, who, rd, er, ok);
    req = '0;
    busy_n = 0;
    n_cmp++;
    if (!ok || lat !== 22) begin
      n_bad++; $display("FAIL tmo_lat: got %0d want 22", lat);
    end
    n_cmp++;
    if ({er, rd} !== {1'b1, 8'h00}) begin
      n_bad++; $display("FAIL tmo_err: got %b/%h want 1/00", er, rd);
    end
    n_cmp++;
    if (nrd - r0 !== 4) begin
      n_bad++; $display("FAIL tmo_reads: got %0d want 4", nrd - r0);
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid;
    int r0, d0, w0;
    bit seen;
    r0 = nrd;
    d0 = ndone;
    seen = 0;
    busy_n = 1000;
    req = 2'b01;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (nrd > r0) begin
        seen = 1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL rstmid_poll: no poll read, want one"); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({psel, pen, pwr, gnt, done, busy, err} !== '0) begin
      n_bad++;
      $display("FAIL rstmid_zero: psel=%b pen=%b gnt=%b busy=%b want 0", psel, pen, gnt, busy);
    end
    req = '0;
    busy_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    w0 = nwr;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (ndone !== d0) begin
      n_bad++; $display("FAIL rstmid_done: got %0d pulses want 0", ndone - d0);
    end
    n_cmp++;
    if ({nwr - w0, wa[w0], wdv[w0]} !== {32'd1, 16'h0040, CFG}) begin
      n_bad++;
      $display("FAIL rstmid_cfg: got n=%0d %h=%h want 1 0040=%h",
               nwr - w0, wa[w0], wdv[w0], CFG);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_polls();
    test_stall();
`ifdef SPI_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
